// File: rtl/reserved_slot_arbiter_if.sv
// Gate-side bundle for the reserved-slot arbiter: load path, two request/grant
// channels, the response strobe and the published occupancy map.
interface reserved_slot_arbiter_if #(
  parameter int N_SLOTS = 16,
  parameter int FLAT_W  = 5
) ();
  logic              load_en;
  logic [N_SLOTS:0]  load_map;
  logic              entry_req;
  logic [FLAT_W-1:0] entry_flat;
  logic              entry_gnt;
  logic              exit_req;
  logic [FLAT_W-1:0] exit_flat;
  logic              exit_gnt;
  logic              resp_valid;
  logic              resp_ok;
  logic              resp_exit;
  logic              resp_range;
  logic [FLAT_W-1:0] resp_flat;
  logic [N_SLOTS:0]  occ_map;
  logic [FLAT_W:0]   occ_count;
  logic              busy;

  modport master (
    output load_en, load_map, entry_req, entry_flat, exit_req, exit_flat,
    input  entry_gnt, exit_gnt, resp_valid, resp_ok, resp_exit, resp_range,
           resp_flat, occ_map, occ_count, busy
  );

  modport slave (
    input  load_en, load_map, entry_req, entry_flat, exit_req, exit_flat,
    output entry_gnt, exit_gnt, resp_valid, resp_ok, resp_exit, resp_range,
           resp_flat, occ_map, occ_count, busy
  );
endinterface

// File: rtl/reserved_slot_arbiter.sv
// Sole owner of the reserved-slot occupancy map: arbitrates entry/exit gate
// requests round-robin and checks/updates one flat bit per transaction.
module reserved_slot_arbiter #(
  parameter int N_SLOTS = 16,
  parameter int FLAT_W  = 5
) (
  input logic                    clk_i,
  input logic                    rst_i,
  reserved_slot_arbiter_if.slave bus
);
  localparam int MAP_W = N_SLOTS + 1;
  localparam logic [FLAT_W-1:0] MAX_FLAT = FLAT_W'(N_SLOTS);
  localparam logic [FLAT_W:0]   CNT_ONE  = (FLAT_W+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [MAP_W-1:0]  occ_map_q;
  logic [FLAT_W:0]   occ_count_q;
  logic [FLAT_W-1:0] flat_q;
  logic              exit_q;
  logic              rr_exit_q;
  logic              busy_q;
  logic              resp_valid_q;
  logic              resp_ok_q;
  logic              resp_exit_q;
  logic              resp_range_q;
  logic [FLAT_W-1:0] resp_flat_q;

  logic              entry_win;
  logic              exit_win;
  logic [MAP_W-1:0]  map_d;
  logic [FLAT_W:0]   count_d;
  logic              ok_d;
  logic              range_d;
  logic [MAP_W-1:0]  flat_mask;

  function automatic logic [FLAT_W:0] popcount(input logic [MAP_W-1:0] map);
    logic [FLAT_W:0] cnt;
    cnt = (FLAT_W+1)'(0);
    for (int k = 0; k < MAP_W; k++) begin
      cnt = cnt + (FLAT_W+1)'(map[k]);
    end
    return cnt;
  endfunction

  // Grant decision: only in IDLE, load wins, ties go to the side not served last
  always_comb begin
    entry_win = 1'b0;
    exit_win  = 1'b0;
    if ((state_q == ST_IDLE) && !rst_i && !bus.load_en) begin
      if (bus.entry_req && bus.exit_req) begin
        entry_win = rr_exit_q;
        exit_win  = !rr_exit_q;
      end else begin
        entry_win = bus.entry_req;
        exit_win  = bus.exit_req;
      end
    end else begin
      entry_win = 1'b0;
      exit_win  = 1'b0;
    end
  end

  // Check-and-update of the latched flat, applied on the EXEC edge
  always_comb begin
    map_d     = occ_map_q;
    count_d   = occ_count_q;
    ok_d      = 1'b0;
    range_d   = 1'b0;
    flat_mask = MAP_W'(1) << flat_q;
    if (flat_q > MAX_FLAT) begin
      range_d = 1'b1;
    end else if (!exit_q && !occ_map_q[flat_q]) begin
      map_d   = occ_map_q | flat_mask;
      count_d = occ_count_q + CNT_ONE;
      ok_d    = 1'b1;
    end else if (exit_q && occ_map_q[flat_q]) begin
      map_d   = occ_map_q & ~flat_mask;
      count_d = occ_count_q - CNT_ONE;
      ok_d    = 1'b1;
    end else begin
      ok_d    = 1'b0;
    end
  end

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      occ_map_q    <= '0;
      occ_count_q  <= '0;
      flat_q       <= '0;
      exit_q       <= 1'b0;
      rr_exit_q    <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_exit_q  <= 1'b0;
      resp_range_q <= 1'b0;
      resp_flat_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.load_en) begin
            occ_map_q   <= bus.load_map;
            occ_count_q <= popcount(bus.load_map);
          end else if (entry_win || exit_win) begin
            flat_q    <= exit_win ? bus.exit_flat : bus.entry_flat;
            exit_q    <= exit_win;
            rr_exit_q <= exit_win;
            busy_q    <= 1'b1;
            state_q   <= ST_EXEC;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_EXEC: begin
          occ_map_q    <= map_d;
          occ_count_q  <= count_d;
          resp_valid_q <= 1'b1;
          resp_ok_q    <= ok_d;
          resp_exit_q  <= exit_q;
          resp_range_q <= range_d;
          resp_flat_q  <= flat_q;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.entry_gnt  = entry_win;
  assign bus.exit_gnt   = exit_win;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_ok    = resp_ok_q;
  assign bus.resp_exit  = resp_exit_q;
  assign bus.resp_range = resp_range_q;
  assign bus.resp_flat  = resp_flat_q;
  assign bus.occ_map    = occ_map_q;
  assign bus.occ_count  = occ_count_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_reserved_slot_arbiter.sv
// Directed bench for reserved_slot_arbiter: a reference occupancy model fills a
// response scoreboard at each grant; responses are popped and compared on arrival.
module tb_reserved_slot_arbiter;
  localparam int N_SLOTS = 16;
  localparam int FLAT_W  = 5;

  typedef struct {
    bit          is_exit;
    logic [4:0]  flat;
    bit          ok;
    bit          range;
    int          cyc;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fails = 0;
  int    last_gnt = 0;
  int    prev_gnt = 0;
  exp_t  sb[$];
  logic [16:0] m_map = 17'd0;
  int    m_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reserved_slot_arbiter_if #(.N_SLOTS(N_SLOTS), .FLAT_W(FLAT_W)) bus ();
  reserved_slot_arbiter #(.N_SLOTS(N_SLOTS), .FLAT_W(FLAT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp();
    exp_t e;
    if (bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_ok",      32'(bus.resp_ok),    32'(e.ok));
        check("resp_exit",    32'(bus.resp_exit),  32'(e.is_exit));
        check("resp_range",   32'(bus.resp_range), 32'(e.range));
        check("resp_flat",    32'(bus.resp_flat),  32'(e.flat));
        check("resp_latency", 32'(cyc),            32'(e.cyc + 2));
        check("resp_map",     32'(bus.occ_map),    32'(m_map));
        check("resp_count",   32'(bus.occ_count),  32'(m_count));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_resp();
  endtask

  task automatic grant_rec(input bit is_exit, input logic [4:0] flat);
    exp_t e;
    e.is_exit = is_exit;
    e.flat    = flat;
    e.cyc     = cyc;
    e.range   = (flat > 5'd16);
    e.ok      = 1'b0;
    if (!e.range) begin
      if (!is_exit && !m_map[flat]) begin
        m_map[flat] = 1'b1;
        m_count++;
        e.ok = 1'b1;
      end else if (is_exit && m_map[flat]) begin
        m_map[flat] = 1'b0;
        m_count--;
        e.ok = 1'b1;
      end
    end
    sb.push_back(e);
    prev_gnt = last_gnt;
    last_gnt = cyc;
  endtask

  // Called just after an edge with requests already driven
  task automatic serve(input int max_cycles);
    int n = 0;
    bit e_g, x_g;
    while ((bus.entry_req || bus.exit_req) && n < max_cycles) begin
      #1;
      e_g = bus.entry_gnt;
      x_g = bus.exit_gnt;
      if (e_g && x_g) check("double_gnt", 32'd1, 32'd0);
      if (e_g) grant_rec(1'b0, bus.entry_flat);
      if (x_g) grant_rec(1'b1, bus.exit_flat);
      tick();
      if (e_g) bus.entry_req = 1'b0;
      if (x_g) bus.exit_req = 1'b0;
      n++;
    end
    if (bus.entry_req || bus.exit_req) begin
      check("grant_timeout", 32'd0, 32'd1);
      bus.entry_req = 1'b0;
      bus.exit_req  = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 8) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    tick();
    check("map_idle",   32'(bus.occ_map),   32'(m_map));
    check("count_idle", 32'(bus.occ_count), 32'(m_count));
    check("busy_idle",  32'(bus.busy),      32'd0);
  endtask

  task automatic txn(input bit is_exit, input logic [4:0] flat);
    if (is_exit) begin
      bus.exit_flat = flat;
      bus.exit_req  = 1'b1;
    end else begin
      bus.entry_flat = flat;
      bus.entry_req  = 1'b1;
    end
    serve(8);
    drain();
  endtask

  task automatic do_load(input logic [16:0] map);
    bus.load_map = map;
    bus.load_en  = 1'b1;
    #1;
    check("load_no_gnt", 32'(bus.entry_gnt | bus.exit_gnt), 32'd0);
    tick();
    bus.load_en = 1'b0;
    m_map   = map;
    m_count = $countones(map);
    check("load_map",   32'(bus.occ_map),   32'(m_map));
    check("load_count", 32'(bus.occ_count), 32'(m_count));
  endtask

  initial begin
    int c0;
    bus.load_en = 1'b0;  bus.load_map = 17'd0;
    bus.entry_req = 1'b0; bus.entry_flat = 5'd0;
    bus.exit_req = 1'b0;  bus.exit_flat = 5'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_map",   32'(bus.occ_map),    32'd0);
    check("rst_count", 32'(bus.occ_count),  32'd0);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_ok",    32'(bus.resp_ok),    32'd0);
    check("rst_busy",  32'(bus.busy),       32'd0);
    rst = 1'b0;
    tick();

    // 1: first entry, then 2: repeat entry, exit, repeat exit
    txn(1'b0, 5'd3);
    check("t1_bit3",  32'(bus.occ_map[3]), 32'd1);
    check("t1_count", 32'(bus.occ_count),  32'd1);
    txn(1'b0, 5'd3);
    txn(1'b1, 5'd3);
    check("t2_bit3", 32'(bus.occ_map[3]), 32'd0);
    txn(1'b1, 5'd3);

    // 3: simultaneous entry/exit, entry served first
    do_load(17'h00080);
    bus.entry_flat = 5'd5; bus.exit_flat = 5'd7;
    bus.entry_req = 1'b1;  bus.exit_req = 1'b1;
    serve(12);
    check("t3_gnt_spacing", 32'(last_gnt - prev_gnt), 32'd3);
    drain();
    check("t3_bit5", 32'(bus.occ_map[5]), 32'd1);
    check("t3_bit7", 32'(bus.occ_map[7]), 32'd0);

    // 4: out-of-range flat, then the top flat
    txn(1'b0, 5'd17);
    txn(1'b0, 5'd16);
    check("t4_bit16", 32'(bus.occ_map[16]), 32'd1);

    // 5: load, then load colliding with an entry request
    do_load(17'h100F0);
    check("t5_count5", 32'(bus.occ_count), 32'd5);
    bus.entry_flat = 5'd0;
    bus.entry_req  = 1'b1;
    do_load(17'h100F0);
    c0 = cyc;
    serve(8);
    check("t5_gnt_next", 32'(last_gnt), 32'(c0));
    drain();

    // 6: reset during EXEC drops the transaction
    bus.entry_flat = 5'd9;
    bus.entry_req  = 1'b1;
    #1;
    check("t6_gnt", 32'(bus.entry_gnt), 32'd1);
    tick();
    bus.entry_req = 1'b0;
    bus.exit_flat = 5'd5;
    bus.exit_req  = 1'b1;
    check("t6_busy_exec", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_map = 17'd0;
    m_count = 0;
    #1;
    check("t6_map",      32'(bus.occ_map),    32'd0);
    check("t6_count",    32'(bus.occ_count),  32'd0);
    check("t6_busy",     32'(bus.busy),       32'd0);
    check("t6_valid",    32'(bus.resp_valid), 32'd0);
    check("t6_exit_gnt", 32'(bus.exit_gnt),   32'd1);
    if (bus.exit_gnt) grant_rec(1'b1, bus.exit_flat);
    tick();
    bus.exit_req = 1'b0;
    drain();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
